// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
//   rx_state_t    : receiver FSM state encoding
//   PAR_NONE/ODD/EVEN : values accepted by the PARITY parameter
//   exp_parity()  : parity bit a transmitter would send for a data word
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Word is zero-extended to 9 bits by the caller; the extra zeros do not
  // change the XOR reduction.
  function automatic logic exp_parity(input logic [8:0] word, input int mode);
    return (mode == PAR_ODD) ? ~(^word) : (^word);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write request and data (dropped when full unless popping)
//   pop      : read request (ignored when empty)
//   full, empty, count : occupancy status (count is 0..DEPTH)
//   head     : entry at the read pointer, valid while !empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with a small receive FIFO, sticky error flags and an LED
// register.
//   clk, rst        : clock, asynchronous active-high reset
//   uart_in         : asynchronous serial line, idle high
//   uart_to_cpu_buf : FIFO head (fall-through), read_int : FIFO non-empty
//   cpu_end_read    : pop strobe; also clears the sticky flags
//   rx_count        : FIFO occupancy
//   frame_err, parity_err, overrun : sticky status
//   leds_array, write_leds, leds   : LED register write port and value
// Parameter limits: CLKS_PER_BIT >= 4, DATA_BITS 5..9, PARITY 0/1/2,
// FIFO_DEPTH a power of two >= 2.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_in,
  output logic [DATA_BITS-1:0]          uart_to_cpu_buf,
  output logic                          read_int,
  input  logic                          cpu_end_read,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic [7:0]                    leds_array,
  input  logic                          write_leds,
  output logic [7:0]                    leds
);

  // Wide enough for both CLKS_PER_BIT-1 and CLKS_PER_BIT/2.
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);

  logic                 sync1, rx_s, rx_prev;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 bad;
  logic                 tick;
  logic [8:0]           data9;
  logic                 par_exp;
  logic                 stop_tick, push, set_frame, set_par, set_ovr;
  logic                 fifo_full, fifo_empty;

  // Two-flop synchroniser plus one delay flop for falling-edge detection.
  // All reset to the idle (high) level so release never looks like a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= uart_in;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  always_comb begin
    data9 = '0;
    data9[DATA_BITS-1:0] = shreg;
  end

  assign par_exp = exp_parity(data9, PARITY);
  assign tick    = (cnt == '0);

  // The counter runs down to zero; each zero is a sample point. The first
  // half-bit load centres every later sample in its bit cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      bad     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= START;
            cnt   <= HALF_BIT;
          end
        end
        START: begin
          if (!tick) cnt <= cnt - CW'(1);
          else if (!rx_s) begin
            state   <= DATA;
            cnt     <= FULL_M1;
            bit_idx <= '0;
            bad     <= 1'b0;
          end else begin
            state <= IDLE;  // line back high at mid-bit: a glitch, no flag
          end
        end
        DATA: begin
          if (!tick) cnt <= cnt - CW'(1);
          else begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};  // LSB arrives first
            cnt   <= FULL_M1;
            if (bit_idx == 4'(DATA_BITS - 1))
              state <= (PARITY != PAR_NONE) ? PAR : STOP;
            else
              bit_idx <= bit_idx + 4'd1;
          end
        end
        PAR: begin
          if (!tick) cnt <= cnt - CW'(1);
          else begin
            if (rx_s != par_exp) bad <= 1'b1;
            state <= STOP;
            cnt   <= FULL_M1;
          end
        end
        STOP: begin
          if (!tick) cnt <= cnt - CW'(1);
          else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_tick = (state == STOP) && tick;
  assign push      = stop_tick && rx_s && !bad;
  assign set_frame = stop_tick && !rx_s;
  assign set_par   = (PARITY != PAR_NONE) && (state == PAR) && tick && (rx_s != par_exp);
  // A full FIFO popped in the same cycle still takes the frame.
  assign set_ovr   = push && fifo_full && !cpu_end_read;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (cpu_end_read),
    .din   (shreg),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rx_count),
    .head  (uart_to_cpu_buf)
  );

  assign read_int = !fifo_empty;

  // Sticky flags: any read strobe clears all three, a new event in the
  // same cycle takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= set_frame | (frame_err  & ~cpu_end_read);
      parity_err <= set_par   | (parity_err & ~cpu_end_read);
      overrun    <= set_ovr   | (overrun    & ~cpu_end_read);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) leds <= '0;
    else if (write_leds) leds <= leds_array;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  localparam int CPB = 16, DB = 8, DEPTH = 4;

  logic clk = 1'b0, rst;
  logic uart_in, uart_in2, cpu_end_read, cpu_end_read2, write_leds;
  logic [7:0] leds_array;
  logic [7:0] rx_buf_a, rx_buf_b, leds_a, leds_b;
  logic [2:0] cnt_a, cnt_b;
  logic read_int_a, read_int_b, fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;

  int n_cmp = 0, n_err = 0;
  logic [7:0] q[$];
  bit m_fe, m_pe, m_ov;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(0), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .uart_in(uart_in), .uart_to_cpu_buf(rx_buf_a), .read_int(read_int_a),
    .cpu_end_read(cpu_end_read), .rx_count(cnt_a), .frame_err(fe_a), .parity_err(pe_a),
    .overrun(ov_a), .leds_array(leds_array), .write_leds(write_leds), .leds(leds_a));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(2), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .uart_in(uart_in2), .uart_to_cpu_buf(rx_buf_b), .read_int(read_int_b),
    .cpu_end_read(cpu_end_read2), .rx_count(cnt_b), .frame_err(fe_b), .parity_err(pe_b),
    .overrun(ov_b), .leds_array(leds_array), .write_leds(write_leds), .leds(leds_b));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) uart_in = v; else uart_in2 = v;
  endtask

  task automatic set_pop(input int sel, input logic v);
    if (sel == 0) cpu_end_read = v; else cpu_end_read2 = v;
  endtask

  // Reference: a read strobe clears flags and removes the oldest word if any.
  task automatic model_pop();
    m_fe = 0; m_pe = 0; m_ov = 0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic model_frame(input logic [7:0] d, input bit stop, input bit pop_on_push);
    if (pop_on_push) model_pop();
    if (!stop) m_fe = 1;
    else if (q.size() < DEPTH) q.push_back(d);
    else m_ov = 1;
  endtask

  // Drive one frame starting at a negedge, one bit per CPB clocks. With
  // pop_on_push the read strobe is placed on the stop-sample edge: two
  // synchroniser flops plus the edge-detect register put the receiver three
  // edges behind the line, then half a bit, then one bit per remaining bit.
  task automatic send_frame(input int sel, input logic [7:0] data, input bit has_par,
                            input bit par_val, input bit stop, input bit pop_on_push);
    logic [11:0] bits;
    int n, t, p;
    bits = '0;
    for (int i = 0; i < DB; i++) bits[1+i] = data[i];
    n = 1 + DB;
    if (has_par) begin bits[n] = par_val; n++; end
    bits[n] = stop; n++;
    p = 3 + CPB/2 + CPB*(n-1);
    t = 0;
    for (int b = 0; b < n; b++) begin
      set_line(sel, bits[b]);
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk); t++;
        if (pop_on_push && t == p) set_pop(sel, 1'b1);
        if (pop_on_push && t == p + 1) set_pop(sel, 1'b0);
      end
    end
    set_line(sel, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic pop(input int sel);
    set_pop(sel, 1'b1);
    @(negedge clk);
    set_pop(sel, 1'b0);
    @(negedge clk);
    if (sel == 0) model_pop();
  endtask

  task automatic test_reset();
    rst = 1; uart_in = 1; uart_in2 = 1; cpu_end_read = 0; cpu_end_read2 = 0;
    write_leds = 1; leds_array = 8'hC3;
    repeat (3) @(negedge clk);
    n_cmp++; if (leds_a !== 8'h00) begin n_err++; $display("FAIL reset_leds got %h want 00", leds_a); end
    n_cmp++; if (read_int_a !== 1'b0) begin n_err++; $display("FAIL reset_read_int got %b want 0", read_int_a); end
    n_cmp++; if (cnt_a !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", cnt_a); end
    n_cmp++; if (rx_buf_a !== 8'h00) begin n_err++; $display("FAIL reset_buf got %h want 00", rx_buf_a); end
    n_cmp++; if ({fe_a, pe_a, ov_a} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {fe_a, pe_a, ov_a}); end
    write_leds = 0;
    rst = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_leds();
    logic [7:0] v;
    for (int k = 0; k < 3; k++) begin
      v = 8'($urandom_range(0, 255));
      leds_array = v; write_leds = 1;
      @(negedge clk);
      write_leds = 0; leds_array = ~v;
      @(negedge clk);
      n_cmp++; if (leds_a !== v) begin n_err++; $display("FAIL leds_hold got %h want %h", leds_a, v); end
    end
  endtask

  task automatic test_single();
    int lat;
    lat = -1;
    fork
      send_frame(0, 8'hA5, 0, 0, 1, 0);
      for (int i = 1; i <= 156; i++) begin
        @(posedge clk); #1;
        if (read_int_a && lat < 0) lat = i;
      end
    join
    model_frame(8'hA5, 1, 0);
    n_cmp++; if (lat < 0) begin n_err++; $display("FAIL single_latency got none want read_int within 156 cycles"); end
    n_cmp++; if (rx_buf_a !== 8'hA5) begin n_err++; $display("FAIL single_buf got %h want a5", rx_buf_a); end
    n_cmp++; if (cnt_a !== 3'd1) begin n_err++; $display("FAIL single_count got %0d want 1", cnt_a); end
    pop(0);
    n_cmp++; if (read_int_a !== 1'b0) begin n_err++; $display("FAIL single_pop_read_int got %b want 0", read_int_a); end
  endtask

  task automatic test_glitch();
    uart_in = 0;
    repeat (5) @(negedge clk);
    uart_in = 1;
    repeat (40) @(negedge clk);
    n_cmp++; if (cnt_a !== 3'd0) begin n_err++; $display("FAIL glitch_count got %0d want 0", cnt_a); end
    n_cmp++; if ({fe_a, pe_a, ov_a} !== 3'b000) begin n_err++; $display("FAIL glitch_flags got %b want 000", {fe_a, pe_a, ov_a}); end
    send_frame(0, 8'h5A, 0, 0, 1, 0);
    model_frame(8'h5A, 1, 0);
    n_cmp++; if (rx_buf_a !== 8'h5A || cnt_a !== 3'd1) begin n_err++; $display("FAIL glitch_next_frame got %h/%0d want 5a/1", rx_buf_a, cnt_a); end
    pop(0);
  endtask

  task automatic test_frame_err();
    send_frame(0, 8'h3C, 0, 0, 0, 0);
    model_frame(8'h3C, 0, 0);
    n_cmp++; if (fe_a !== 1'b1) begin n_err++; $display("FAIL frame_err_set got %b want 1", fe_a); end
    n_cmp++; if (cnt_a !== 3'd0) begin n_err++; $display("FAIL frame_err_count got %0d want 0", cnt_a); end
    pop(0);
    n_cmp++; if (fe_a !== 1'b0) begin n_err++; $display("FAIL frame_err_clear got %b want 0", fe_a); end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) begin
      send_frame(0, 8'(i), 0, 0, 1, 0);
      model_frame(8'(i), 1, 0);
    end
    n_cmp++; if (cnt_a !== 3'd4) begin n_err++; $display("FAIL overrun_count got %0d want 4", cnt_a); end
    n_cmp++; if (ov_a !== 1'b1) begin n_err++; $display("FAIL overrun_flag got %b want 1", ov_a); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (rx_buf_a !== 8'(i)) begin n_err++; $display("FAIL overrun_pop%0d got %h want %h", i, rx_buf_a, 8'(i)); end
      pop(0);
      if (i == 1) begin
        n_cmp++; if (ov_a !== 1'b0) begin n_err++; $display("FAIL overrun_clear got %b want 0", ov_a); end
      end
    end
    n_cmp++; if (read_int_a !== 1'b0) begin n_err++; $display("FAIL overrun_drained got %b want 0", read_int_a); end
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < 4; i++) begin
      send_frame(0, 8'h10 + 8'(i), 0, 0, 1, 0);
      model_frame(8'h10 + 8'(i), 1, 0);
    end
    send_frame(0, 8'h14, 0, 0, 1, 1);
    model_frame(8'h14, 1, 1);
    n_cmp++; if (cnt_a !== 3'd4 || ov_a !== 1'b0) begin n_err++; $display("FAIL full_pushpop got cnt %0d ov %b want 4 0", cnt_a, ov_a); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (rx_buf_a !== 8'h10 + 8'(i)) begin n_err++; $display("FAIL full_pushpop_drain got %h want %h", rx_buf_a, 8'h10 + 8'(i)); end
      pop(0);
    end
  endtask

  task automatic test_parity();
    // Even parity: 0x07 has three ones, so the correct parity bit is 1.
    send_frame(1, 8'h07, 1, 0, 1, 0);
    n_cmp++; if (pe_b !== 1'b1 || cnt_b !== 3'd0) begin n_err++; $display("FAIL parity_bad got pe %b cnt %0d want 1 0", pe_b, cnt_b); end
    pop(1);
    send_frame(1, 8'h07, 1, 1, 1, 0);
    n_cmp++; if (pe_b !== 1'b0 || cnt_b !== 3'd1 || rx_buf_b !== 8'h07) begin n_err++; $display("FAIL parity_good got pe %b cnt %0d buf %h want 0 1 07", pe_b, cnt_b, rx_buf_b); end
    pop(1);
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit stop, pp;
    int np;
    for (int it = 0; it < 24; it++) begin
      d = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      pp = ($urandom_range(0, 2) == 0);
      send_frame(0, d, 0, 0, stop, pp);
      model_frame(d, stop, pp);
      n_cmp++; if (cnt_a !== 3'(q.size())) begin n_err++; $display("FAIL rand_count it %0d got %0d want %0d", it, cnt_a, q.size()); end
      n_cmp++; if (read_int_a !== (q.size() > 0)) begin n_err++; $display("FAIL rand_read_int it %0d got %b", it, read_int_a); end
      n_cmp++; if ({fe_a, pe_a, ov_a} !== {m_fe, m_pe, m_ov}) begin n_err++; $display("FAIL rand_flags it %0d got %b want %b", it, {fe_a, pe_a, ov_a}, {m_fe, m_pe, m_ov}); end
      if (q.size() > 0) begin
        n_cmp++; if (rx_buf_a !== q[0]) begin n_err++; $display("FAIL rand_head it %0d got %h want %h", it, rx_buf_a, q[0]); end
      end
      np = $urandom_range(0, 2);
      for (int k = 0; k < np; k++) begin
        pop(0);
        n_cmp++; if (cnt_a !== 3'(q.size())) begin n_err++; $display("FAIL rand_pop_count it %0d got %0d want %0d", it, cnt_a, q.size()); end
        if (q.size() > 0) begin
          n_cmp++; if (rx_buf_a !== q[0]) begin n_err++; $display("FAIL rand_pop_head it %0d got %h want %h", it, rx_buf_a, q[0]); end
        end
      end
    end
    while (q.size() > 0) pop(0);
    pop(0);
  endtask

  task automatic test_reset_mid();
    leds_array = 8'hF0; write_leds = 1;
    @(negedge clk);
    write_leds = 0;
    send_frame(0, 8'h11, 0, 0, 1, 0);
    send_frame(0, 8'h22, 0, 0, 0, 0);
    // Partial 0x55: start bit, bit0=1, then half of bit1.
    uart_in = 0; repeat (CPB) @(negedge clk);
    uart_in = 1; repeat (CPB) @(negedge clk);
    uart_in = 0; repeat (CPB/2) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    n_cmp++; if (cnt_a !== 3'd0 || read_int_a !== 1'b0) begin n_err++; $display("FAIL midrst_fifo got cnt %0d ri %b want 0 0", cnt_a, read_int_a); end
    n_cmp++; if (rx_buf_a !== 8'h00 || leds_a !== 8'h00) begin n_err++; $display("FAIL midrst_regs got buf %h leds %h want 00 00", rx_buf_a, leds_a); end
    n_cmp++; if ({fe_a, pe_a, ov_a} !== 3'b000) begin n_err++; $display("FAIL midrst_flags got %b want 000", {fe_a, pe_a, ov_a}); end
    rst = 0;
    q.delete(); m_fe = 0; m_pe = 0; m_ov = 0;
    uart_in = 1;
    repeat (30) @(negedge clk);
    send_frame(0, 8'h99, 0, 0, 1, 0);
    model_frame(8'h99, 1, 0);
    n_cmp++; if (rx_buf_a !== 8'h99 || cnt_a !== 3'd1) begin n_err++; $display("FAIL midrst_next got %h/%0d want 99/1", rx_buf_a, cnt_a); end
    pop(0);
  endtask

  initial begin
    test_reset();
    test_leds();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_push_pop_full();
    test_parity();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
